// File: rtl/img_pkg.sv
// Shared constants and types for the image-row packer and its row buffer.
// Defining IMG_PACK_MSB_FIRST_EN places pixel 0 in the top bits of a row; otherwise it goes in the bottom bits.
package img_pkg;

  localparam int PIX_W       = 12;
  localparam int PIX_PER_ROW = 256;
  localparam int ROW_BITS    = PIX_W * PIX_PER_ROW;
  localparam int ADDR_W      = 9;
  localparam int NUM_ROWS    = 512;
  localparam int COL_W       = $clog2(PIX_PER_ROW);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } pack_state_t;

  // Bit offset of pixel k within a packed row.
  function automatic int slot_lsb(input int k);
`ifdef IMG_PACK_MSB_FIRST_EN
    return (PIX_PER_ROW - 1 - k) * PIX_W;
`else
    return k * PIX_W;
`endif
  endfunction

endpackage

// File: rtl/img_row_packer_if.sv
// Pixel-stream, frame-control and buffer-write-port signals of the row packer.
// The slave modport is the packer side; the master modport is the source/buffer side.
interface img_row_packer_if;
  import img_pkg::*;

  logic                start;
  logic [ADDR_W-1:0]   last_row;
  logic                pix_valid;
  logic [PIX_W-1:0]    pix_data;
  logic                pix_ready;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [ROW_BITS-1:0] wdata;
  logic                busy;
  logic                done;

  modport slave (
    input  start, last_row, pix_valid, pix_data,
    output pix_ready, we, waddr, wdata, busy, done
  );

  modport master (
    output start, last_row, pix_valid, pix_data,
    input  pix_ready, we, waddr, wdata, busy, done
  );

endinterface

// File: rtl/img_row_packer.sv
// Packs a stream of 12-bit pixels into 3072-bit rows and writes each finished row
// to the image buffer in one cycle; pulses done after the frame's last row.
module img_row_packer
  import img_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  img_row_packer_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_FILL  = FILL;
  localparam logic [1:0] ST_WRITE = WRITE;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]          state_q, state_d;
  logic [ADDR_W-1:0]   row_q, row_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_BITS-1:0] row_buf_q, row_buf_d;
  logic                accept;

  assign accept = (state_q == ST_FILL) && bus.pix_valid;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    last_d  = last_q;
    col_d   = col_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_FILL;
          row_d   = '0;
          col_d   = '0;
          last_d  = bus.last_row;
        end
      end
      ST_FILL: begin
        if (accept) begin
          col_d = col_q + COL_W'(1);
          if (col_q == COL_W'(PIX_PER_ROW - 1)) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (row_q == last_q) begin
          state_d = ST_DONE;
        end else begin
          row_d   = row_q + ADDR_W'(1);
          col_d   = '0;
          state_d = ST_FILL;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Each slot has its own enable decoded from col, so only one 12-bit field loads per accept.
  always_comb begin
    row_buf_d = row_buf_q;
    for (int k = 0; k < PIX_PER_ROW; k++) begin
      if (accept && (col_q == COL_W'(k))) row_buf_d[slot_lsb(k) +: PIX_W] = bus.pix_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      last_q    <= '0;
      col_q     <= '0;
      row_buf_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      last_q    <= last_d;
      col_q     <= col_d;
      row_buf_q <= row_buf_d;
    end
  end

  // All outputs decode from registered state, never from pix_valid.
  assign bus.pix_ready = (state_q == ST_FILL);
  assign bus.we        = (state_q == ST_WRITE);
  assign bus.waddr     = row_q;
  assign bus.wdata     = row_buf_q;
  assign bus.busy      = (state_q == ST_FILL) || (state_q == ST_WRITE);
  assign bus.done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_img_row_packer.sv
// Directed frame sequence with random pixels/stalls, checked against a row model
// that assembles each expected row from the accepted pixels.
module tb_img_row_packer;
  import img_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  img_row_packer_if bus ();

  img_row_packer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_row(input string tag, input logic [ROW_BITS-1:0] obs,
                         input logic [ROW_BITS-1:0] exp);
    int first;
    first = -1;
    total++;
    assert (obs === exp) else begin
      bad++;
      for (int k = PIX_PER_ROW - 1; k >= 0; k--)
        if (obs[k*PIX_W +: PIX_W] !== exp[k*PIX_W +: PIX_W]) first = k;
      if (first < 0) first = 0;
      $error("FAIL %s bitslot %0d observed=%0h expected=%0h", tag, first,
             obs[first*PIX_W +: PIX_W], exp[first*PIX_W +: PIX_W]);
    end
  endtask

  function automatic logic [ROW_BITS-1:0] pack_row(input logic [PIX_W-1:0] p [PIX_PER_ROW]);
    logic [ROW_BITS-1:0] r;
    r = '0;
    for (int k = 0; k < PIX_PER_ROW; k++) begin
`ifdef IMG_PACK_MSB_FIRST_EN
      r[(PIX_PER_ROW - 1 - k)*PIX_W +: PIX_W] = p[k];
`else
      r[k*PIX_W +: PIX_W] = p[k];
`endif
    end
    return r;
  endfunction

  task automatic reset_check(input string tag);
    chk({tag, "_ready"}, 32'(bus.pix_ready), 0);
    chk({tag, "_we"},    32'(bus.we),        0);
    chk({tag, "_waddr"}, 32'(bus.waddr),     0);
    chk({tag, "_busy"},  32'(bus.busy),      0);
    chk({tag, "_done"},  32'(bus.done),      0);
    chk_row({tag, "_wdata"}, bus.wdata, '0);
  endtask

  // stall: 0 continuous, 1 every other cycle, 2 random; pat: 0 col index, 1 random, 2 0xABC then zeros.
  task automatic do_frame(input int lr, input int stall, input int pat, input bit disturb,
                          input int abort_row, input int abort_col);
    logic [PIX_W-1:0] pix [PIX_PER_ROW];
    int  col, cyc, first_acc;
    bit  v;
    @(negedge clk);
    chk("idle_busy",  32'(bus.busy),      0);
    chk("idle_ready", 32'(bus.pix_ready), 0);
    bus.start    = 1'b1;
    bus.last_row = ADDR_W'(lr);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_rise", 32'(bus.busy), 1);
    cyc = 0;
    first_acc = -1;
    for (int r = 0; r <= lr; r++) begin
      col = 0;
      while (col < PIX_PER_ROW) begin
        if (r == abort_row && col == abort_col) begin
          rst_n = 1'b0;
          #1;
          reset_check("abort");
          bus.pix_valid = 1'b1;
          repeat (3) begin
            @(negedge clk);
            chk("abort_we",    32'(bus.we),        0);
            chk("abort_ready", 32'(bus.pix_ready), 0);
          end
          rst_n = 1'b1;
          return;
        end
        chk($sformatf("fill_ready_r%0d", r), 32'(bus.pix_ready), 1);
        chk($sformatf("fill_we_r%0d", r),    32'(bus.we),        0);
        case (stall)
          0:       v = 1'b1;
          1:       v = (cyc % 2) == 0;
          default: v = ($urandom_range(2) != 0);
        endcase
        bus.pix_valid = v;
        if (pat == 0)      bus.pix_data = PIX_W'(col);
        else if (pat == 1) bus.pix_data = PIX_W'($urandom);
        else               bus.pix_data = (col == 0) ? 12'hABC : 12'h000;
        if (disturb && r == 0 && col == 50) begin
          bus.start    = 1'b1;
          bus.last_row = 9'd5;
        end else begin
          bus.start = 1'b0;
        end
        if (v) begin
          pix[col] = bus.pix_data;
          if (first_acc < 0) first_acc = cyc;
          col++;
        end
        @(negedge clk);
        cyc++;
      end
      bus.pix_valid = 1'b1;
      bus.pix_data  = 12'hFFF;
      bus.start     = 1'b0;
      chk($sformatf("we_r%0d", r),        32'(bus.we),        1);
      chk($sformatf("waddr_r%0d", r),     32'(bus.waddr),     32'(r));
      chk($sformatf("wr_ready_r%0d", r),  32'(bus.pix_ready), 0);
      chk($sformatf("wr_busy_r%0d", r),   32'(bus.busy),      1);
      chk_row($sformatf("wdata_r%0d", r), bus.wdata, pack_row(pix));
      if (stall == 0) chk($sformatf("we_time_r%0d", r), 32'(cyc - first_acc), 32'(256 + 257*r));
      @(negedge clk);
      cyc++;
    end
    bus.pix_valid = 1'b0;
    chk("done_pulse", 32'(bus.done), 1);
    chk("done_busy",  32'(bus.busy), 0);
    chk("done_we",    32'(bus.we),   0);
    if (stall == 0) chk("done_time", 32'(cyc - first_acc), 32'(257*lr + 257));
    @(negedge clk);
    chk("post_done",  32'(bus.done),      0);
    chk("post_busy",  32'(bus.busy),      0);
    chk("post_ready", 32'(bus.pix_ready), 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.last_row  = '0;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    repeat (2) @(negedge clk);
    reset_check("por");
    rst_n = 1'b1;

    do_frame(0, 1, 0, 1'b0, -1, -1);
    do_frame(2, 0, 1, 1'b0, -1, -1);
    do_frame(1, 2, 1, 1'b1, -1, -1);
    do_frame(0, 0, 2, 1'b0, -1, -1);
    do_frame(5, 2, 1, 1'b0, 3, 100);
    do_frame(0, 0, 1, 1'b0, -1, -1);
    do_frame(63, 0, 1, 1'b0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
